// File: rtl/unidade_controle_multiciclo.sv
// Multicycle RV32I control unit: Moore FSM sequencing FETCH/DECODE/EXECUTE/MEM/WB
// with a memory ready handshake and a sticky trap for unsupported encodings.
module unidade_controle_multiciclo #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       alu_lsb,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic [2:0] imm_src,
    output logic [3:0] state,
    output logic       illegal_instr,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        ALUWB    = 4'd7,
        EXEC_I   = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t cur_state, nxt_state;

    logic       pcw_c, irw_c, adr_c, mrd_c, mwr_c, rw_c, ill_c, done_c;
    logic [1:0] rs_c, sa_c, sb_c;
    alu_op_t    ac_c;
    logic       f7b5;
    logic       sra_sel;
    logic       unused_funct7;

    assign f7b5          = funct7[5];
    assign sra_sel       = (funct3 == 3'b101) && f7b5;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    function automatic alu_op_t arith_op(input logic [2:0] f3, input logic sub);
        alu_op_t op;
        case (f3)
            3'b000:  op = sub ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= state_t'(RESET_STATE);
        else        cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        pcw_c     = 1'b0;
        irw_c     = 1'b0;
        adr_c     = 1'b0;
        mrd_c     = 1'b0;
        mwr_c     = 1'b0;
        rw_c      = 1'b0;
        ill_c     = 1'b0;
        done_c    = 1'b0;
        rs_c      = 2'b00;
        sa_c      = 2'b00;
        sb_c      = 2'b00;
        ac_c      = ALU_AND;

        case (cur_state)
            FETCH: begin
                mrd_c = 1'b1;
                sb_c  = 2'b10;
                ac_c  = ALU_ADD;
                rs_c  = 2'b10;
                pcw_c = mem_ready;
                irw_c = mem_ready;
                if (mem_ready) nxt_state = DECODE;
            end
            DECODE: begin
                sa_c = 2'b01;
                sb_c = 2'b01;
                ac_c = ALU_ADD;
                case (opcode)
                    OP_LOAD, OP_STORE: nxt_state = MEMADR;
                    OP_R:              nxt_state = EXEC_R;
                    OP_I:              nxt_state = EXEC_I;
                    OP_JAL:            nxt_state = JAL;
                    OP_BRANCH:         nxt_state = BRANCH;
                    default:           nxt_state = ILLEGAL;
                endcase
            end
            MEMADR: begin
                sa_c      = 2'b10;
                sb_c      = 2'b01;
                ac_c      = ALU_ADD;
                nxt_state = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_c = 1'b1;
                mrd_c = 1'b1;
                if (mem_ready) nxt_state = MEMWB;
            end
            MEMWB: begin
                rs_c      = 2'b01;
                rw_c      = 1'b1;
                done_c    = 1'b1;
                nxt_state = FETCH;
            end
            MEMWRITE: begin
                adr_c  = 1'b1;
                mwr_c  = 1'b1;
                done_c = mem_ready;
                if (mem_ready) nxt_state = FETCH;
            end
            EXEC_R: begin
                sa_c      = 2'b10;
                ac_c      = arith_op(funct3, f7b5);
                nxt_state = sra_sel ? ILLEGAL : ALUWB;
            end
            EXEC_I: begin
                sa_c      = 2'b10;
                sb_c      = 2'b01;
                ac_c      = arith_op(funct3, 1'b0);
                nxt_state = sra_sel ? ILLEGAL : ALUWB;
            end
            ALUWB: begin
                rw_c      = 1'b1;
                done_c    = 1'b1;
                nxt_state = FETCH;
            end
            JAL: begin
                // ALUOut still holds the target from DECODE; ALU now forms OldPC+4 for rd
                sa_c      = 2'b01;
                sb_c      = 2'b10;
                ac_c      = ALU_ADD;
                pcw_c     = 1'b1;
                nxt_state = ALUWB;
            end
            BRANCH: begin
                sa_c      = 2'b10;
                done_c    = 1'b1;
                nxt_state = FETCH;
                case (funct3)
                    3'b000: begin ac_c = ALU_SUB;  pcw_c = zero;     end
                    3'b001: begin ac_c = ALU_SUB;  pcw_c = !zero;    end
                    3'b100: begin ac_c = ALU_SLT;  pcw_c = alu_lsb;  end
                    3'b101: begin ac_c = ALU_SLT;  pcw_c = !alu_lsb; end
                    3'b110: begin ac_c = ALU_SLTU; pcw_c = alu_lsb;  end
                    3'b111: begin ac_c = ALU_SLTU; pcw_c = !alu_lsb; end
                    default: begin
                        done_c    = 1'b0;
                        nxt_state = ILLEGAL;
                    end
                endcase
            end
            ILLEGAL: begin
                ill_c     = 1'b1;
                nxt_state = ILLEGAL;
            end
            default: nxt_state = FETCH;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_LOAD, OP_I, OP_JALR: imm_src = 3'b000;
            OP_STORE:               imm_src = 3'b001;
            OP_BRANCH:              imm_src = 3'b010;
            OP_JAL:                 imm_src = 3'b011;
            default:                imm_src = 3'b000;
        endcase
    end

    // Enables are forced low while reset is held, since FETCH would otherwise strobe memory
    assign pc_write      = pcw_c  & rst_n;
    assign ir_write      = irw_c  & rst_n;
    assign mem_read      = mrd_c  & rst_n;
    assign mem_write     = mwr_c  & rst_n;
    assign reg_write     = rw_c   & rst_n;
    assign illegal_instr = ill_c  & rst_n;
    assign instr_done    = done_c & rst_n;

    assign adr_src     = adr_c;
    assign result_src  = rs_c;
    assign alu_src_a   = sa_c;
    assign alu_src_b   = sb_c;
    assign alu_control = ac_c;
    assign state       = cur_state;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Scoreboard bench for the multicycle control unit: directed instruction sequences
// push per-cycle expected outputs; a negedge monitor pops and compares.
module tb_unidade_controle_multiciclo;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       alu_lsb;
    logic       mem_ready;
    logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [3:0] alu_control;
    logic [2:0] imm_src;
    logic [3:0] state;
    logic       illegal_instr, instr_done;

    unidade_controle_multiciclo #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .alu_lsb(alu_lsb), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .state(state),
        .illegal_instr(illegal_instr), .instr_done(instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal_instr, instr_done}
    localparam logic [7:0] EN_NONE   = 8'b0000_0000;
    localparam logic [7:0] EN_FETCH  = 8'b1101_0000;
    localparam logic [7:0] EN_FWAIT  = 8'b0001_0000;
    localparam logic [7:0] EN_MRD    = 8'b0011_0000;
    localparam logic [7:0] EN_WB     = 8'b0000_0101;
    localparam logic [7:0] EN_MWR    = 8'b0010_1001;
    localparam logic [7:0] EN_JAL    = 8'b1000_0000;
    localparam logic [7:0] EN_BTAKEN = 8'b1000_0001;
    localparam logic [7:0] EN_BNOT   = 8'b0000_0001;
    localparam logic [7:0] EN_ILL    = 8'b0000_0010;

    localparam logic [31:0] I_SUB   = 32'h40B50533;
    localparam logic [31:0] I_LW    = 32'h0002A303;
    localparam logic [31:0] I_SW    = 32'h0062A223;
    localparam logic [31:0] I_BEQ   = 32'h00B50463;
    localparam logic [31:0] I_BNE   = 32'h00B51463;
    localparam logic [31:0] I_BGEU  = 32'h00B57463;
    localparam logic [31:0] I_JAL   = 32'h0080006F;
    localparam logic [31:0] I_SLTIU = 32'h00153513;
    localparam logic [31:0] I_LUI   = 32'h000012B7;

    typedef struct {
        string       nm;
        logic [24:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic [24:0] obs;
    assign obs = {state, pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                  illegal_instr, instr_done, result_src, alu_src_a, alu_src_b,
                  alu_control, imm_src};

    task automatic step(input string nm, input logic rst, input logic rdy,
                        input logic [31:0] ir, input logic z, input logic lsb,
                        input logic [3:0] st, input logic [7:0] en,
                        input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [3:0] ac, input logic [2:0] imm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rst;
        mem_ready = rdy;
        opcode    = ir[6:0];
        funct3    = ir[14:12];
        funct7    = ir[31:25];
        zero      = z;
        alu_lsb   = lsb;
        e.nm = nm;
        e.v  = {st, en, rs, sa, sb, ac, imm};
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (obs !== e.v) begin
                    bad++;
                    $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                             e.nm, obs[24:21], obs, e.v[24:21], e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0; mem_ready = 1'b1; opcode = '0; funct3 = '0; funct7 = '0;
        zero = 1'b0; alu_lsb = 1'b0;

        for (int i = 0; i < 3; i++)
            step("reset", 0, 1, 32'h0, 0, 0, 4'd0, EN_NONE, 2'b10, 2'b00, 2'b10, 4'b0010, 3'b000);

        // sub a0,a0,a1
        step("sub_fetch",  1, 1, I_SUB, 0, 0, 4'd0, EN_FETCH, 2'b10, 2'b00, 2'b10, 4'b0010, 3'b000);
        step("sub_decode", 1, 1, I_SUB, 0, 0, 4'd1, EN_NONE,  2'b00, 2'b01, 2'b01, 4'b0010, 3'b000);
        step("sub_exec",   1, 1, I_SUB, 0, 0, 4'd6, EN_NONE,  2'b00, 2'b10, 2'b00, 4'b0110, 3'b000);
        step("sub_aluwb",  1, 1, I_SUB, 0, 0, 4'd7, EN_WB,    2'b00, 2'b00, 2'b00, 4'b0000, 3'b000);

        // lw with two wait states
        step("lw_fetch",   1, 1, I_LW, 0, 0, 4'd0, EN_FETCH, 2'b10, 2'b00, 2'b10, 4'b0010, 3'b000);
        step("lw_decode",  1, 1, I_LW, 0, 0, 4'd1, EN_NONE,  2'b00, 2'b01, 2'b01, 4'b0010, 3'b000);
        step("lw_memadr",  1, 1, I_LW, 0, 0, 4'd2, EN_NONE,  2'b00, 2'b10, 2'b01, 4'b0010, 3'b000);
        step("lw_wait1",   1, 0, I_LW, 0, 0, 4'd3, EN_MRD,   2'b00, 2'b00, 2'b00, 4'b0000, 3'b000);
        step("lw_wait2",   1, 0, I_LW, 0, 0, 4'd3, EN_MRD,   2'b00, 2'b00, 2'b00, 4'b0000, 3'b000);
        step("lw_ready",   1, 1, I_LW, 0, 0, 4'd3, EN_MRD,   2'b00, 2'b00, 2'b00, 4'b0000, 3'b000);
        step("lw_memwb",   1, 1, I_LW, 0, 0, 4'd4, EN_WB,    2'b01, 2'b00, 2'b00, 4'b0000, 3'b000);

        // sw
        step("sw_fetch",   1, 1, I_SW, 0, 0, 4'd0, EN_FETCH, 2'b10, 2'b00, 2'b10, 4'b0010, 3'b001);
        step("sw_decode",  1, 1, I_SW, 0, 0, 4'd1, EN_NONE,  2'b00, 2'b01, 2'b01, 4'b0010, 3'b001);
        step("sw_memadr",  1, 1, I_SW, 0, 0, 4'd2, EN_NONE,  2'b00, 2'b10, 2'b01, 4'b0010, 3'b001);
        step("sw_write",   1, 1, I_SW, 0, 0, 4'd5, EN_MWR,   2'b00, 2'b00, 2'b00, 4'b0000, 3'b001);

        // beq taken (zero=1)
        step("beq_fetch",  1, 1, I_BEQ, 1, 0, 4'd0,  EN_FETCH,  2'b10, 2'b00, 2'b10, 4'b0010, 3'b010);
        step("beq_decode", 1, 1, I_BEQ, 1, 0, 4'd1,  EN_NONE,   2'b00, 2'b01, 2'b01, 4'b0010, 3'b010);
        step("beq_branch", 1, 1, I_BEQ, 1, 0, 4'd10, EN_BTAKEN, 2'b00, 2'b10, 2'b00, 4'b0110, 3'b010);

        // bne not taken (zero=1)
        step("bne_fetch",  1, 1, I_BNE, 1, 0, 4'd0,  EN_FETCH, 2'b10, 2'b00, 2'b10, 4'b0010, 3'b010);
        step("bne_decode", 1, 1, I_BNE, 1, 0, 4'd1,  EN_NONE,  2'b00, 2'b01, 2'b01, 4'b0010, 3'b010);
        step("bne_branch", 1, 1, I_BNE, 1, 0, 4'd10, EN_BNOT,  2'b00, 2'b10, 2'b00, 4'b0110, 3'b010);

        // bgeu taken (alu_lsb=0)
        step("bgeu_fetch",  1, 1, I_BGEU, 0, 0, 4'd0,  EN_FETCH,  2'b10, 2'b00, 2'b10, 4'b0010, 3'b010);
        step("bgeu_decode", 1, 1, I_BGEU, 0, 0, 4'd1,  EN_NONE,   2'b00, 2'b01, 2'b01, 4'b0010, 3'b010);
        step("bgeu_branch", 1, 1, I_BGEU, 0, 0, 4'd10, EN_BTAKEN, 2'b00, 2'b10, 2'b00, 4'b1000, 3'b010);

        // jal
        step("jal_fetch",  1, 1, I_JAL, 0, 0, 4'd0, EN_FETCH, 2'b10, 2'b00, 2'b10, 4'b0010, 3'b011);
        step("jal_decode", 1, 1, I_JAL, 0, 0, 4'd1, EN_NONE,  2'b00, 2'b01, 2'b01, 4'b0010, 3'b011);
        step("jal_jal",    1, 1, I_JAL, 0, 0, 4'd9, EN_JAL,   2'b00, 2'b01, 2'b10, 4'b0010, 3'b011);
        step("jal_aluwb",  1, 1, I_JAL, 0, 0, 4'd7, EN_WB,    2'b00, 2'b00, 2'b00, 4'b0000, 3'b011);

        // sltiu
        step("sltiu_fetch",  1, 1, I_SLTIU, 0, 0, 4'd0, EN_FETCH, 2'b10, 2'b00, 2'b10, 4'b0010, 3'b000);
        step("sltiu_decode", 1, 1, I_SLTIU, 0, 0, 4'd1, EN_NONE,  2'b00, 2'b01, 2'b01, 4'b0010, 3'b000);
        step("sltiu_exec",   1, 1, I_SLTIU, 0, 0, 4'd8, EN_NONE,  2'b00, 2'b10, 2'b01, 4'b1000, 3'b000);
        step("sltiu_aluwb",  1, 1, I_SLTIU, 0, 0, 4'd7, EN_WB,    2'b00, 2'b00, 2'b00, 4'b0000, 3'b000);

        // lui is unsupported: fetch stall, then trap
        step("lui_fwait",  1, 0, I_LUI, 0, 0, 4'd0, EN_FWAIT, 2'b10, 2'b00, 2'b10, 4'b0010, 3'b000);
        step("lui_fetch",  1, 1, I_LUI, 0, 0, 4'd0, EN_FETCH, 2'b10, 2'b00, 2'b10, 4'b0010, 3'b000);
        step("lui_decode", 1, 1, I_LUI, 0, 0, 4'd1, EN_NONE,  2'b00, 2'b01, 2'b01, 4'b0010, 3'b000);
        for (int i = 0; i < 10; i++)
            step("illegal_hold", 1, 1, I_LUI, 0, 0, 4'd11, EN_ILL, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000);

        // reset asserted between edges must take effect before the next edge
        step("async_reset", 0, 1, I_LUI, 0, 0, 4'd0, EN_NONE, 2'b10, 2'b00, 2'b10, 4'b0010, 3'b000);
        step("post_reset",  1, 1, I_SUB, 0, 0, 4'd0, EN_FETCH, 2'b10, 2'b00, 2'b10, 4'b0010, 3'b000);
        step("post_decode", 1, 1, I_SUB, 0, 0, 4'd1, EN_NONE,  2'b00, 2'b01, 2'b01, 4'b0010, 3'b000);

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unidade_controle_multiciclo.md
Name: unidade_controle_multiciclo

Overview:
Moore-style FSM controller for the multicycle RV32I datapath: one shared ALU, one unified instruction/data memory, and IR, OldPC, Data and ALUOut registers. It replaces the single-cycle decoder by sequencing each instruction through FETCH/DECODE/EXECUTE/MEM/WB states. It handles a ready handshake with the unified memory and traps unsupported encodings into a sticky illegal state.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); kept as a parameter for bring-up only.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
zero  in  1  ALU result == 0
alu_lsb  in  1  ALU result bit 0 (SLT/SLTU outcome)
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  PC <= result bus
ir_write  out  1  IR <= mem rdata; OldPC <= PC
adr_src  out  1  0: PC, 1: ALUOut drives memory address
mem_read  out  1  read strobe
mem_write  out  1  write strobe
reg_write  out  1  register file write rd
result_src  out  2  00 ALUOut, 01 Data reg, 10 ALU result
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
alu_control  out  4  0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 XOR, 0101 SRL, 0110 SUB, 0111 SLT, 1000 SLTU
imm_src  out  3  000 I, 001 S, 010 B, 011 J; combinational from opcode; 000 for any other opcode
state  out  4  current state, for debug
illegal_instr  out  1  high while in ILLEGAL
instr_done  out  1  one-cycle pulse on the last cycle of each instruction

Behaviour:
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC_R 6, ALUWB 7, EXEC_I 8, JAL 9, BRANCH 10, ILLEGAL 11.
- State register is reset asynchronously. While rst_n=0: state=FETCH and pc_write, ir_write, mem_read, mem_write, reg_write, instr_done, illegal_instr are all 0.
- Reset deassertion mid-instruction restarts at FETCH; no partial write may be issued.
- Outputs are a function of state only, except pc_write/ir_write (gated by mem_ready or branch outcome) and imm_src/alu_control (decoded from the IR fields). Unlisted outputs in a state are 0.
- FETCH: adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, ADD, result_src=10. ir_write=pc_write=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, ADD (branch/JAL target into ALUOut). Next state:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1101111 -> JAL
  - 1100011 -> BRANCH
  - anything else -> ILLEGAL
- MEMADR: alu_src_a=10, alu_src_b=01, ADD. Go to MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, mem_read=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1; go to FETCH.
- MEMWRITE: adr_src=1, mem_write=1, held until mem_ready. instr_done=mem_ready; go to FETCH when mem_ready.
- EXEC_R: alu_src_a=10, alu_src_b=00. funct3 mapping:
  - 000: SUB if funct7[5], else ADD
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND
  - 101: SRL if funct7[5]=0; SRA (funct7[5]=1) -> ILLEGAL
  - Otherwise go to ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=01. Same mapping as EXEC_R, except 000 is always ADD. 101 with funct7[5]=1 -> ILLEGAL; otherwise go to ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1; go to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_write=1 (PC <= target). Go to ALUWB, which writes OldPC+4 into rd.
- BRANCH: alu_src_a=10, alu_src_b=00, result_src=00, instr_done=1; go to FETCH. ALU op and taken condition by funct3:
  - 000 SUB, taken=zero
  - 001 SUB, taken=!zero
  - 100 SLT, taken=alu_lsb
  - 101 SLT, taken=!alu_lsb
  - 110 SLTU, taken=alu_lsb
  - 111 SLTU, taken=!alu_lsb
  - pc_write=taken.
  - funct3 010/011: no pc_write, no instr_done; go to ILLEGAL instead.
- ILLEGAL: sticky until reset. All enables 0, illegal_instr=1.
- Memory strobes are held stable while waiting on mem_ready; the controller never issues mem_read and mem_write in the same cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 -> state=0 and all enables 0; release -> FETCH with mem_read=1, pc_write=1, ir_write=1.
- R-type: IR=0x40B50533 (sub a0,a0,a1), mem_ready=1 -> states 0,1,6,7,0; alu_control=0110 in EXEC_R; reg_write=1 and instr_done=1 only in ALUWB.
- LW with 2 wait states: IR=0x0002A303, mem_ready low for 2 cycles in MEMREAD -> stays in state 3 for 3 cycles with adr_src=1, mem_read=1; then MEMWB with result_src=01, reg_write=1.
- SW: IR=0x0062A223, mem_ready=1 -> states 0,1,2,5,0; mem_write=1 for exactly 1 cycle; reg_write never asserted.
- Branches: BEQ with zero=1 -> pc_write=1 in BRANCH; BNE with zero=1 -> pc_write=0; BGEU with alu_lsb=0 -> pc_write=1 with alu_control=1000.
- Illegal: opcode 0110111 (LUI) -> DECODE goes to state 11, illegal_instr=1 held for 10 cycles; assert rst_n=0 mid-stall -> state 0 asynchronously.
